// File: rtl/beat_editor.sv
// Front-panel step editor: debounced buttons move a cursor and edit 4-bit pitches per step.
// Optional live record from the playback position when BEAT_EDITOR_LIVE_RECORD_EN is defined.
module beat_editor #(
    parameter int NUM_BEATS       = 16,
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_clear,
    input  logic [$clog2(NUM_BEATS)-1:0] beat_count,
`ifdef BEAT_EDITOR_LIVE_RECORD_EN
    input  logic                         rec_en,
    input  logic [3:0]                   rec_pitch,
`endif
    output logic [NUM_BEATS*4-1:0]       beats,
    output logic [$clog2(NUM_BEATS)-1:0] cursor,
    output logic [3:0]                   cursor_pitch,
    output logic                         edit_strobe
);

    localparam int CW    = $clog2(NUM_BEATS);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int NBTN  = 5;

    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;
    localparam int B_CLEAR = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  deb;
    logic [NBTN-1:0]  deb_q;
    logic [NBTN-1:0]  ev;
    logic [CNT_W-1:0] cnt [NBTN];

    assign raw = {btn_clear, btn_down, btn_up, btn_right, btn_left};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press events only; releases are ignored.
    assign ev = deb & ~deb_q;

`ifdef BEAT_EDITOR_LIVE_RECORD_EN
    logic [CW-1:0] beat_count_q;
    logic          rec_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count;
        end
    end

    assign rec_hit = rec_en && (beat_count != beat_count_q);
`else
    logic unused_beat_count;
    assign unused_beat_count = ^beat_count;
`endif

    logic [NUM_BEATS*4-1:0] beats_nxt;
    logic [CW-1:0]          cursor_nxt;

    assign cursor_pitch = beats[{cursor, 2'b00} +: 4];

    always_comb begin
        beats_nxt  = beats;
        cursor_nxt = cursor;
        if (ev[B_CLEAR]) begin
            beats_nxt  = '0;
            cursor_nxt = '0;
        end else begin
            // Pitch edit uses the pre-move cursor so a simultaneous move cannot redirect it.
            if (ev[B_UP] && !ev[B_DOWN] && (cursor_pitch != 4'hF)) begin
                beats_nxt[{cursor, 2'b00} +: 4] = cursor_pitch + 4'd1;
            end else if (ev[B_DOWN] && !ev[B_UP] && (cursor_pitch != 4'h0)) begin
                beats_nxt[{cursor, 2'b00} +: 4] = cursor_pitch - 4'd1;
            end
`ifdef BEAT_EDITOR_LIVE_RECORD_EN
            // Written after the button edit so recording wins on the same step.
            if (rec_hit) begin
                beats_nxt[{beat_count, 2'b00} +: 4] = rec_pitch;
            end
`endif
            if (ev[B_RIGHT] && !ev[B_LEFT]) begin
                cursor_nxt = cursor + 1'b1;
            end else if (ev[B_LEFT] && !ev[B_RIGHT]) begin
                cursor_nxt = cursor - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats       <= '0;
            cursor      <= '0;
            edit_strobe <= 1'b0;
        end else begin
            beats       <= beats_nxt;
            cursor      <= cursor_nxt;
            edit_strobe <= (beats_nxt != beats);
        end
    end

endmodule

// File: tb/tb_beat_editor.sv
// Self-checking bench for beat_editor with a step-array reference model and random presses.
module tb_beat_editor;

    localparam int NB = 16;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_left, btn_right, btn_up, btn_down, btn_clear;
    logic [3:0]  beat_count;
`ifdef BEAT_EDITOR_LIVE_RECORD_EN
    logic        rec_en;
    logic [3:0]  rec_pitch;
`endif
    logic [63:0] beats;
    logic [3:0]  cursor;
    logic [3:0]  cursor_pitch;
    logic        edit_strobe;

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;
    int model [NB];
    int mcur;

    beat_editor #(.NUM_BEATS(NB), .DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_clear    (btn_clear),
        .beat_count   (beat_count),
`ifdef BEAT_EDITOR_LIVE_RECORD_EN
        .rec_en       (rec_en),
        .rec_pitch    (rec_pitch),
`endif
        .beats        (beats),
        .cursor       (cursor),
        .cursor_pitch (cursor_pitch),
        .edit_strobe  (edit_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (edit_strobe === 1'b1) strobes++;

    function automatic logic [63:0] model_bus();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r[i*4 +: 4] = 4'(model[i]);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) model[i] = 0;
        mcur = 0;
    endfunction

    // mask bits: 0 left, 1 right, 2 up, 3 down, 4 clear. Returns 1 if a stored step changed.
    function automatic bit model_apply(input logic [4:0] m);
        int old [NB];
        bit changed;
        for (int i = 0; i < NB; i++) old[i] = model[i];
        if (m[4]) begin
            model_reset();
        end else begin
            if (m[2] && !m[3]) model[mcur] = (model[mcur] + 1 > 15) ? 15 : model[mcur] + 1;
            if (m[3] && !m[2]) model[mcur] = (model[mcur] - 1 < 0) ? 0 : model[mcur] - 1;
            if (m[1] && !m[0]) mcur = (mcur + 1) % NB;
            if (m[0] && !m[1]) mcur = (mcur + NB - 1) % NB;
        end
        changed = 0;
        for (int i = 0; i < NB; i++) if (old[i] != model[i]) changed = 1;
        return changed;
    endfunction

    task automatic set_btns(input logic [4:0] m);
        {btn_clear, btn_down, btn_up, btn_right, btn_left} = m;
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk);
        set_btns(m);
        repeat (10) @(negedge clk);
        set_btns(5'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic press_model(input logic [4:0] m);
        bit c;
        c = model_apply(m);
        press(m);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_btns(5'b0);
        beat_count = '0;
`ifdef BEAT_EDITOR_LIVE_RECORD_EN
        rec_en = 1'b0;
        rec_pitch = '0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (beats !== 64'h0) begin errors++; $display("FAIL reset_beats: got %h want 0", beats); end
        checks++; if (cursor !== 4'd0) begin errors++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
        checks++; if (edit_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", edit_strobe); end
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cursor();
        int s0;
        bit c;
        s0 = strobes;
        @(negedge clk);
        btn_right = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e == 6) begin
                checks++; if (cursor !== 4'd0) begin errors++; $display("FAIL latency_early: cursor %0d want 0 at edge 6", cursor); end
            end
            if (e == 7) begin
                checks++; if (cursor !== 4'd1) begin errors++; $display("FAIL latency_edge7: cursor %0d want 1", cursor); end
            end
        end
        repeat (3) @(negedge clk);
        btn_right = 1'b0;
        repeat (10) @(negedge clk);
        c = model_apply(5'b00010);
        press_model(5'b00001);
        press_model(5'b00001);
        checks++; if (cursor !== 4'(mcur) || mcur != 15) begin errors++; $display("FAIL left_wrap: cursor %0d want 15", cursor); end
        checks++; if (strobes != s0) begin errors++; $display("FAIL cursor_no_strobe: strobes %0d want %0d", strobes - s0, 0); end
    endtask

    task automatic test_glitch_up();
        int s0;
        s0 = strobes;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (beats !== model_bus() || strobes != s0) begin errors++; $display("FAIL glitch: beats %h strobes %0d want %h strobes 0", beats, strobes - s0, model_bus()); end
        press_model(5'b00010);
        s0 = strobes;
        repeat (3) press_model(5'b00100);
        checks++; if (beats[3:0] !== 4'd3) begin errors++; $display("FAIL up_three: nibble0 %0d want 3", beats[3:0]); end
        checks++; if (strobes - s0 != 3) begin errors++; $display("FAIL up_strobes: got %0d want 3", strobes - s0); end
    endtask

    task automatic test_saturate();
        int s0;
        repeat (5) press_model(5'b00010);
        repeat (15) press_model(5'b00100);
        checks++; if (beats[23:20] !== 4'd15 || cursor !== 4'd5) begin errors++; $display("FAIL sat_setup: nibble5 %0d cursor %0d want 15 5", beats[23:20], cursor); end
        s0 = strobes;
        press_model(5'b00100);
        checks++; if (beats[23:20] !== 4'd15 || strobes != s0) begin errors++; $display("FAIL sat_up: nibble5 %0d strobes %0d want 15 0", beats[23:20], strobes - s0); end
        s0 = strobes;
        repeat (16) press_model(5'b01000);
        checks++; if (beats[23:20] !== 4'd0 || strobes - s0 != 15) begin errors++; $display("FAIL sat_down: nibble5 %0d strobes %0d want 0 15", beats[23:20], strobes - s0); end
    endtask

    task automatic test_clear();
        int s0;
        press_model(5'b10000);
        for (int i = 1; i < NB; i++) begin
            press_model(5'b00010);
            repeat (i) press_model(5'b00100);
        end
        checks++; if (beats !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL load_pattern: got %h want fedcba9876543210", beats); end
        repeat (6) press_model(5'b00001);
        checks++; if (cursor !== 4'd9) begin errors++; $display("FAIL clear_setup: cursor %0d want 9", cursor); end
        s0 = strobes;
        press_model(5'b10100);
        checks++; if (beats !== 64'h0 || cursor !== 4'd0) begin errors++; $display("FAIL clear_up: beats %h cursor %0d want 0 0", beats, cursor); end
        checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL clear_strobe: got %0d want 1", strobes - s0); end
        s0 = strobes;
        press_model(5'b10000);
        checks++; if (strobes != s0) begin errors++; $display("FAIL clear_zero_strobe: got %0d want 0", strobes - s0); end
    endtask

    task automatic test_simultaneous();
        bit c;
        bit seen;
        repeat (2) press_model(5'b00010);
        repeat (4) press_model(5'b00100);
        @(negedge clk);
        set_btns(5'b00110);
        c = model_apply(5'b00110);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (cursor !== 4'd2) begin
                seen = 1;
                checks++; if (cursor !== 4'd3 || beats[11:8] !== 4'd5) begin errors++; $display("FAIL same_edge: cursor %0d nibble2 %0d want 3 5", cursor, beats[11:8]); end
                checks++; if (edit_strobe !== 1'b1) begin errors++; $display("FAIL strobe_timing: got %b want 1", edit_strobe); end
                @(posedge clk); #1;
                checks++; if (edit_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b want 0", edit_strobe); end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL same_edge_timeout: cursor %0d never left 2", cursor);
        end
        @(negedge clk);
        set_btns(5'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        logic [4:0] m;
        int s0;
        bit c;
        for (int n = 0; n < 80; n++) begin
            m = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) m[4] = 1'b1;
            s0 = strobes;
            c = model_apply(m);
            press(m);
            checks++;
            if (beats !== model_bus() || cursor !== 4'(mcur) || cursor_pitch !== 4'(model[mcur]) || (strobes - s0) != int'(c)) begin
                errors++;
                $display("FAIL random_%0d mask %b: beats %h cur %0d pitch %0d strobes %0d want %h %0d %0d %0d",
                         n, m, beats, cursor, cursor_pitch, strobes - s0, model_bus(), mcur, model[mcur], int'(c));
            end
        end
    endtask

    task automatic test_reset_hold();
        bit seen;
        @(negedge clk);
        rst = 1'b1;
        btn_right = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cursor !== 4'd0 || beats !== 64'h0) begin errors++; $display("FAIL hold_in_reset: cursor %0d beats %h want 0 0", cursor, beats); end
        rst = 1'b0;
        model_reset();
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (cursor !== 4'd0) seen = 1;
        end
        checks++; if (!seen || cursor !== 4'd1) begin errors++; $display("FAIL hold_through_reset: cursor %0d want 1", cursor); end
        mcur = 1;
        repeat (5) @(negedge clk);
        checks++; if (cursor !== 4'd1) begin errors++; $display("FAIL hold_single_event: cursor %0d want 1", cursor); end
        btn_right = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = strobes;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (15) @(negedge clk);
        checks++; if (beats !== 64'h0 || cursor !== 4'd0 || strobes != s0) begin errors++; $display("FAIL reset_mid: beats %h cursor %0d strobes %0d want 0 0 0", beats, cursor, strobes - s0); end
    endtask

`ifdef BEAT_EDITOR_LIVE_RECORD_EN
    task automatic test_record();
        int s0;
        press_model(5'b00100);
        s0 = strobes;
        @(negedge clk);
        rec_en = 1'b1;
        rec_pitch = 4'd7;
        beat_count = 4'd1;
        @(negedge clk);
        beat_count = 4'd2;
        @(negedge clk);
        model[1] = 7;
        model[2] = 7;
        repeat (2) @(negedge clk);
        checks++; if (beats !== model_bus() || beats[3:0] !== 4'd1) begin errors++; $display("FAIL record: beats %h want %h", beats, model_bus()); end
        checks++; if (strobes - s0 != 2) begin errors++; $display("FAIL record_strobe: got %0d want 2", strobes - s0); end
        rec_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (beats !== 64'h0) begin errors++; $display("FAIL record_reset: beats %h want 0", beats); end
        beat_count = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rec_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (beats !== 64'h0) begin errors++; $display("FAIL record_idle: beats %h want 0", beats); end
        beat_count = 4'd3;
        model[3] = 7;
        repeat (2) @(negedge clk);
        checks++; if (beats !== model_bus()) begin errors++; $display("FAIL record_after_reset: beats %h want %h", beats, model_bus()); end
        rec_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_cursor();
        test_glitch_up();
        test_saturate();
        test_clear();
        test_simultaneous();
        test_random();
        test_reset_hold();
        test_reset_mid();
`ifdef BEAT_EDITOR_LIVE_RECORD_EN
        test_record();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
